// File: rtl/dn_port_arbiter.sv
// dn_port_arbiter: owns the game core's single download/NVRAM port and shares
// it between the HPS ioctl stream and the hiscore/nvram engine. It requests a
// CPU pause around every engine session, holds ioctl off with io_wait while
// a session is in flight, and returns engine reads through a fixed-latency
// pipe that matches the port's read latency.
module dn_port_arbiter #(
  parameter int AW          = 16,   // dn_addr width
  parameter int HS_AW       = 10,   // engine address width, zero-extended to AW
  parameter int RD_LAT      = 2,    // dn_addr valid -> dn_din valid, 1..7
  parameter int NVRAM_INDEX = 4,    // ioctl index that targets NVRAM
  parameter int PAUSE_TO    = 1023  // cycles to wait for cpu_paused
) (
  input  logic             clk_sys,
  input  logic             reset,

  // HPS ioctl stream
  input  logic             io_download,
  input  logic [7:0]       io_index,
  input  logic             io_wr,
  input  logic [24:0]      io_addr,
  input  logic [7:0]       io_dout,
  output logic             io_wait,

  // hiscore/nvram engine
  input  logic             hs_req,
  output logic             hs_gnt,
  input  logic             hs_rd,
  input  logic             hs_wr,
  input  logic [HS_AW-1:0] hs_addr,
  input  logic [7:0]       hs_wdata,
  output logic [7:0]       hs_rdata,
  output logic             hs_rvalid,
  input  logic             hs_done,

  // CPU pause handshake
  output logic             cpu_pause_req,
  input  logic             cpu_paused,

  // download/NVRAM port
  output logic [AW-1:0]    dn_addr,
  output logic [7:0]       dn_data,
  output logic             dn_wr,
  output logic             dn_nvram,
  input  logic [7:0]       dn_din,

  // status
  output logic             busy,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,     // port free
    ST_IO,       // ioctl owns the port
    ST_PAUSE,    // waiting for the CPU to acknowledge the pause
    ST_HS,       // engine owns the port
    ST_RELEASE   // engine done, draining reads before unpausing the CPU
  } state_e;

  localparam int                CNT_W      = 10;
  localparam logic [CNT_W-1:0]  PAUSE_LAST = CNT_W'(PAUSE_TO - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [RD_LAT:0]    rd_pipe_q, rd_pipe_d;
  logic [AW-1:0]      dn_addr_q, dn_addr_d;
  logic [7:0]         dn_data_q, dn_data_d;
  logic               dn_wr_q, dn_wr_d;
  logic               dn_nvram_q, dn_nvram_d;

  logic               io_idx_rom;
  logic               io_idx_nv;
  logic               rd_accept;
  logic [AW-1:0]      hs_addr_ext;
  logic               unused_io_addr_hi;

  assign io_idx_rom  = (io_index == 8'd0);
  assign io_idx_nv   = (io_index == 8'(NVRAM_INDEX));
  assign hs_addr_ext = {{(AW - HS_AW){1'b0}}, hs_addr};

  // Only the low AW bits of the ioctl address reach the port.
  assign unused_io_addr_hi = ^io_addr[24:AW];

  // A read is only taken while granted; a simultaneous write wins and the read is dropped.
  assign rd_accept = (state_q == ST_HS) && hs_rd && !hs_wr;

  // Session sequencing: ioctl priority, pause handshake with timeout, drain on release.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so that
    // no path leaves it unassigned and a latch cannot be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (io_download) begin
          state_d = ST_IO;
        end else if (hs_req) begin
          state_d = ST_PAUSE;
          cnt_d   = '0;
        end
      end
      ST_IO: begin
        if (!io_download) state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        // ioctl can still claim the port because the session has not started.
        if (io_download) begin
          state_d = ST_IO;
        end else if (cpu_paused) begin
          state_d = ST_HS;
        end else if (cnt_q == PAUSE_LAST) begin
          state_d = ST_HS;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HS: begin
        if (hs_done || !hs_req) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Keep the CPU paused until every outstanding read has been returned.
        if ((rd_pipe_q == '0) && !hs_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port mux: next-cycle dn_* value from whichever requester owns the port.
  always_comb begin
    dn_addr_d  = '0;
    dn_data_d  = '0;
    dn_wr_d    = 1'b0;
    dn_nvram_d = 1'b0;
    rd_pipe_d  = {rd_pipe_q[RD_LAT-1:0], rd_accept};
    if (state_d == ST_IO) begin
      // Covers the cycle ioctl claims the port, so its first write is not lost.
      dn_addr_d  = io_addr[AW-1:0];
      dn_data_d  = io_dout;
      dn_wr_d    = io_wr && (io_idx_rom || io_idx_nv);
      dn_nvram_d = io_idx_nv;
    end else if (state_q == ST_HS) begin
      dn_addr_d  = hs_addr_ext;
      dn_data_d  = hs_wdata;
      dn_wr_d    = hs_wr;
      dn_nvram_d = 1'b1;
    end
  end

  // State, counter, sticky error, read pipe and registered port outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      // NOTE: the read pipe is reset like any other state so that no rvalid
      // for a pre-reset read can surface after reset is released.
      rd_pipe_q  <= '0;
      dn_addr_q  <= '0;
      dn_data_q  <= '0;
      dn_wr_q    <= 1'b0;
      dn_nvram_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of its _d; the combinational blocks above use blocking.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_pipe_q  <= rd_pipe_d;
      dn_addr_q  <= dn_addr_d;
      dn_data_q  <= dn_data_d;
      dn_wr_q    <= dn_wr_d;
      dn_nvram_q <= dn_nvram_d;
    end
  end

  // Handshake outputs decode straight from the state register, so reset drops them at once.
  assign busy          = (state_q != ST_IDLE);
  assign hs_gnt        = (state_q == ST_HS);
  assign cpu_pause_req = (state_q == ST_PAUSE) || (state_q == ST_HS) || (state_q == ST_RELEASE);
  assign io_wait       = io_download && ((state_q == ST_HS) || (state_q == ST_RELEASE));
  assign err_timeout   = err_q;

  assign dn_addr   = dn_addr_q;
  assign dn_data   = dn_data_q;
  assign dn_wr     = dn_wr_q;
  assign dn_nvram  = dn_nvram_q;

  // Read data is the port data in the cycle the matching rvalid fires.
  assign hs_rvalid = rd_pipe_q[RD_LAT];
  assign hs_rdata  = hs_rvalid ? dn_din : 8'h00;

endmodule

// File: tb/tb_dn_port_arbiter.sv
// Bench for dn_port_arbiter: ioctl pass-through, pause handshake, engine
// sessions with randomized reads/writes, contention, pause timeout and reset
// during a session. The port is modelled as a byte memory with RD_LAT read
// latency; expected reads are kept in a due-cycle queue.
module tb_dn_port_arbiter;

  localparam int AW          = 16;
  localparam int HS_AW       = 10;
  localparam int RD_LAT      = 2;
  localparam int NVRAM_INDEX = 4;
  localparam int PAUSE_TO    = 1023;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic             io_download;
  logic [7:0]       io_index;
  logic             io_wr;
  logic [24:0]      io_addr;
  logic [7:0]       io_dout;
  logic             io_wait;
  logic             hs_req;
  logic             hs_gnt;
  logic             hs_rd;
  logic             hs_wr;
  logic [HS_AW-1:0] hs_addr;
  logic [7:0]       hs_wdata;
  logic [7:0]       hs_rdata;
  logic             hs_rvalid;
  logic             hs_done;
  logic             cpu_pause_req;
  logic             cpu_paused;
  logic [AW-1:0]    dn_addr;
  logic [7:0]       dn_data;
  logic             dn_wr;
  logic             dn_nvram;
  logic [7:0]       dn_din;
  logic             busy;
  logic             err_timeout;

  dn_port_arbiter #(
    .AW(AW), .HS_AW(HS_AW), .RD_LAT(RD_LAT), .NVRAM_INDEX(NVRAM_INDEX), .PAUSE_TO(PAUSE_TO)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .io_download(io_download), .io_index(io_index), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_wait(io_wait),
    .hs_req(hs_req), .hs_gnt(hs_gnt), .hs_rd(hs_rd), .hs_wr(hs_wr),
    .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_rdata(hs_rdata),
    .hs_rvalid(hs_rvalid), .hs_done(hs_done),
    .cpu_pause_req(cpu_pause_req), .cpu_paused(cpu_paused),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .dn_nvram(dn_nvram),
    .dn_din(dn_din), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Port memory: dn_din shows the byte at the address presented RD_LAT cycles earlier.
  logic [7:0]    mem [0:(1<<HS_AW)-1];
  logic [AW-1:0] addr_hist [RD_LAT];
  always @(posedge clk_sys) begin
    addr_hist[0] <= dn_addr;
    for (int i = 1; i < RD_LAT; i++) addr_hist[i] <= addr_hist[i-1];
  end
  assign dn_din = mem[addr_hist[RD_LAT-1][HS_AW-1:0]];

  // Expected engine reads: each accepted read returns its byte RD_LAT+1 cycles later.
  typedef struct {
    int         due;
    logic [7:0] data;
  } rd_exp_t;
  rd_exp_t rd_q[$];
  int      last_due = 0;

  always @(negedge clk_sys) begin : rv_mon
    logic       exp_rv;
    logic [7:0] exp_d;
    exp_rv = 1'b0;
    exp_d  = 8'h00;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      exp_rv = 1'b1;
      exp_d  = rd_q[0].data;
      void'(rd_q.pop_front());
    end
    check("hs_rvalid", 32'(hs_rvalid), 32'(exp_rv));
    if (exp_rv) check("hs_rdata", 32'(hs_rdata), 32'(exp_d));
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_sys);
  endtask

  // One ioctl beat: the port must show it on the next cycle.
  task automatic io_beat(input logic [7:0] idx, input logic wr, input logic [24:0] a, input logic [7:0] d);
    logic exp_wr;
    logic exp_nv;
    io_index = idx;
    io_wr    = wr;
    io_addr  = a;
    io_dout  = d;
    exp_nv   = (idx == 8'(NVRAM_INDEX));
    exp_wr   = wr && (idx == 8'd0 || exp_nv);
    step();
    io_wr = 1'b0;
    neg();
    check("io_dn_addr",  32'(dn_addr),  32'(a[AW-1:0]));
    check("io_dn_data",  32'(dn_data),  32'(d));
    check("io_dn_wr",    32'(dn_wr),    32'(exp_wr));
    check("io_dn_nvram", 32'(dn_nvram), 32'(exp_nv));
    check("io_busy",     32'(busy),     1);
  endtask

  // Request a session and acknowledge the pause dly cycles later.
  task automatic open_session(input int dly);
    last_due = 0;
    hs_req   = 1'b1;
    for (int i = 1; i <= dly; i++) begin
      step();
      neg();
      check("pause_req_wait", 32'(cpu_pause_req), 1);
      check("gnt_early",      32'(hs_gnt),        0);
    end
    cpu_paused = 1'b1;
    step();
    neg();
    check("gnt",      32'(hs_gnt), 1);
    check("gnt_busy", 32'(busy),   1);
  endtask

  // One engine beat while granted.
  task automatic hs_beat(input logic rd, input logic wr, input logic [HS_AW-1:0] a, input logic [7:0] d);
    hs_rd    = rd;
    hs_wr    = wr;
    hs_addr  = a;
    hs_wdata = d;
    if (rd && !wr) begin
      rd_q.push_back('{cyc + RD_LAT + 1, mem[a]});
      last_due = cyc + RD_LAT + 1;
    end
    step();
    hs_rd = 1'b0;
    hs_wr = 1'b0;
    neg();
    check("hs_dn_addr",  32'(dn_addr),  32'(a));
    check("hs_dn_nvram", 32'(dn_nvram), 1);
    check("hs_dn_wr",    32'(dn_wr),    32'(wr));
    if (wr) check("hs_dn_data", 32'(dn_data), 32'(d));
  endtask

  // End the session; the pause must be held until the last read has returned.
  task automatic close_session();
    logic dropped;
    hs_done = 1'b1;
    hs_req  = 1'b0;
    step();
    hs_done = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 16 && !dropped; i++) begin
      neg();
      check("gnt_after_done", 32'(hs_gnt), 0);
      if (cyc <= last_due) check("pause_held", 32'(cpu_pause_req), 1);
      else if (!cpu_pause_req) dropped = 1'b1;
      if (!dropped) begin
        check("io_wait_in_session", 32'(io_wait), 32'(io_download));
        step();
      end
    end
    check("pause_dropped", 32'(dropped), 1);
    check("idle_after",    32'(busy),    0);
    check("io_wait_idle",  32'(io_wait), 0);
    cpu_paused = 1'b0;
  endtask

  task automatic random_hs_beat();
    logic [HS_AW-1:0] a;
    logic [7:0]       d;
    a = HS_AW'($urandom);
    d = 8'($urandom);
    case ($urandom_range(0, 3))
      0:       hs_beat(1'b1, 1'b0, a, d);
      1:       hs_beat(1'b0, 1'b1, a, d);
      2:       hs_beat(1'b1, 1'b1, a, d);
      default: hs_beat(1'b0, 1'b0, a, d);
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] idx;
    for (int i = 0; i < (1 << HS_AW); i++) mem[i] = 8'($urandom);
    mem[10'h3FF] = 8'h5C;

    reset       = 1'b1;
    io_download = 1'b0; io_index = 8'h00; io_wr = 1'b0; io_addr = '0; io_dout = 8'h00;
    hs_req      = 1'b0; hs_rd = 1'b0; hs_wr = 1'b0; hs_addr = '0; hs_wdata = 8'h00;
    hs_done     = 1'b0; cpu_paused = 1'b0;

    // Reset state
    neg();
    check("rst_busy",      32'(busy),          0);
    check("rst_gnt",       32'(hs_gnt),        0);
    check("rst_pause_req", 32'(cpu_pause_req), 0);
    check("rst_dn_wr",     32'(dn_wr),         0);
    check("rst_dn_addr",   32'(dn_addr),       0);
    check("rst_err",       32'(err_timeout),   0);
    check("rst_io_wait",   32'(io_wait),       0);
    step(); step();
    reset = 1'b0;
    step();

    // ROM / NVRAM download through ioctl
    io_download = 1'b1;
    io_beat(8'd0, 1'b1, 25'h0123, 8'hA5);
    io_beat(8'd3, 1'b1, 25'($urandom), 8'($urandom));
    io_beat(8'(NVRAM_INDEX), 1'b1, 25'($urandom), 8'($urandom));
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       idx = 8'd0;
        1:       idx = 8'(NVRAM_INDEX);
        2:       idx = 8'd3;
        default: idx = 8'($urandom);
      endcase
      io_beat(idx, 1'($urandom), 25'($urandom), 8'($urandom));
    end
    io_download = 1'b0;
    step();
    neg();
    check("io_end_busy",  32'(busy),    0);
    check("io_end_dn_wr", 32'(dn_wr),   0);
    check("io_end_addr",  32'(dn_addr), 0);

    // Directed session: single read at the top address, then a 4-read burst
    open_session(5);
    hs_beat(1'b1, 1'b0, 10'h3FF, 8'h00);
    for (int i = 0; i < 4; i++) hs_beat(1'b1, 1'b0, HS_AW'($urandom), 8'h00);
    close_session();

    // Write, read+write collision, read
    open_session(2);
    hs_beat(1'b0, 1'b1, HS_AW'($urandom), 8'($urandom));
    hs_beat(1'b1, 1'b1, HS_AW'($urandom), 8'($urandom));
    hs_beat(1'b1, 1'b0, HS_AW'($urandom), 8'h00);
    close_session();

    // Randomized sessions
    for (int s = 0; s < 6; s++) begin
      open_session(1 + int'($urandom_range(0, 12)));
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) random_hs_beat();
      close_session();
    end

    // ioctl arriving during PAUSE takes the port before the session starts
    hs_req = 1'b1;
    step();
    neg();
    check("pre_pause_req", 32'(cpu_pause_req), 1);
    io_download = 1'b1;
    io_index    = 8'd0;
    io_wr       = 1'b0;
    step();
    neg();
    check("preempt_pause_req", 32'(cpu_pause_req), 0);
    check("preempt_gnt",       32'(hs_gnt),        0);
    check("preempt_io_wait",   32'(io_wait),       0);
    io_beat(8'd0, 1'b1, 25'($urandom), 8'($urandom));
    hs_req      = 1'b0;
    io_download = 1'b0;
    step();
    neg();
    check("preempt_idle", 32'(busy), 0);

    // Contention: ioctl waits for the whole session, then gets the port
    open_session(3);
    hs_beat(1'b1, 1'b0, HS_AW'($urandom), 8'h00);
    io_download = 1'b1;
    io_index    = 8'd0;
    io_wr       = 1'b0;
    #1;
    check("contend_io_wait", 32'(io_wait), 1);
    hs_beat(1'b1, 1'b0, HS_AW'($urandom), 8'h00);
    check("contend_io_wait_rd", 32'(io_wait), 1);
    check("contend_gnt",        32'(hs_gnt),  1);
    hs_beat(1'b0, 1'b1, HS_AW'($urandom), 8'($urandom));
    check("contend_io_wait_wr", 32'(io_wait), 1);
    close_session();
    io_beat(8'd0, 1'b1, 25'($urandom), 8'($urandom));
    check("contend_io_wait_io", 32'(io_wait), 0);
    io_download = 1'b0;
    step();
    neg();
    check("contend_idle", 32'(busy), 0);

    // Pause timeout: no acknowledge, grant forced after PAUSE_TO cycles
    last_due   = 0;
    hs_req     = 1'b1;
    cpu_paused = 1'b0;
    for (int i = 1; i <= PAUSE_TO; i++) begin
      step();
      neg();
      if (i == 1 || i == PAUSE_TO) begin
        check("to_pause_req", 32'(cpu_pause_req), 1);
        check("to_gnt_early", 32'(hs_gnt),        0);
        check("to_err_early", 32'(err_timeout),   0);
      end
    end
    step();
    neg();
    check("to_gnt", 32'(hs_gnt),      1);
    check("to_err", 32'(err_timeout), 1);
    hs_beat(1'b1, 1'b0, HS_AW'($urandom), 8'h00);
    close_session();
    check("to_err_sticky", 32'(err_timeout), 1);

    // Reset mid-session with two reads in flight
    open_session(2);
    hs_beat(1'b1, 1'b0, HS_AW'($urandom), 8'h00);
    hs_beat(1'b1, 1'b0, HS_AW'($urandom), 8'h00);
    check("err_before_reset", 32'(err_timeout), 1);
    reset = 1'b1;
    rd_q.delete();
    hs_req     = 1'b0;
    cpu_paused = 1'b0;
    #1;
    check("mid_rst_gnt",       32'(hs_gnt),        0);
    check("mid_rst_pause_req", 32'(cpu_pause_req), 0);
    check("mid_rst_rvalid",    32'(hs_rvalid),     0);
    check("mid_rst_err",       32'(err_timeout),   0);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      neg();
      check("post_rst_busy", 32'(busy), 0);
    end
    check("post_rst_err", 32'(err_timeout), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dn_port_arbiter.md
Name: dn_port_arbiter

Overview:
- Owns the single download/NVRAM port (dn_addr/dn_data/dn_wr/dn_nvram/dn_din) of the game core.
- Shares the port between two requesters: the HPS ioctl stream (ROM and NVRAM-restore writes) and the hiscore/nvram engine (session-based reads and writes).
- Sequences the CPU pause handshake around hiscore sessions, and back-pressures ioctl through io_wait while a session is in flight.

Parameters:
- AW, 16, dn_addr width.
- HS_AW, 10, hiscore engine address width (zero-extended to AW).
- RD_LAT, 2, cycles from dn_addr valid to dn_din valid (1..7).
- NVRAM_INDEX, 4, ioctl index that targets NVRAM.
- PAUSE_TO, 1023, cycles to wait for cpu_paused before forcing grant.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- io_download  in  1  ioctl transfer active.
- io_index  in  8  ioctl index.
- io_wr  in  1  ioctl write strobe.
- io_addr  in  25  ioctl address.
- io_dout  in  8  ioctl write data.
- io_wait  out  1  ioctl back-pressure.
- hs_req  in  1  engine requests a session (level).
- hs_gnt  out  1  session granted.
- hs_rd  in  1  read strobe, valid only while hs_gnt.
- hs_wr  in  1  write strobe, valid only while hs_gnt.
- hs_addr  in  HS_AW  engine address.
- hs_wdata  in  8  engine write data.
- hs_rdata  out  8  read data.
- hs_rvalid  out  1  read data valid pulse.
- hs_done  in  1  end-of-session pulse.
- cpu_pause_req  out  1  pause request to CPU/pause block.
- cpu_paused  in  1  CPU pause acknowledge.
- dn_addr  out  AW  port address.
- dn_data  out  8  port write data.
- dn_wr  out  1  port write strobe.
- dn_nvram  out  1  1 = NVRAM target, 0 = ROM target.
- dn_din  in  8  port read data.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky pause-timeout flag.

Behaviour:
- Reset (async): all outputs 0, state IDLE, counters and read pipe cleared. Asserting reset mid-session drops hs_gnt and cpu_pause_req in the same cycle.
- All dn_* outputs are registered: 1-cycle latency from the driving request inputs.
- In IDLE, dn_* = 0.

States:
- IDLE:
  - io_download -> IO (takes priority when both are pending in the same cycle).
  - else hs_req -> PAUSE.
- IO:
  - dn_addr = io_addr[AW-1:0]; dn_data = io_dout.
  - dn_wr = io_wr & (io_index == 0 | io_index == NVRAM_INDEX); writes under any other index are dropped.
  - dn_nvram = (io_index == NVRAM_INDEX).
  - io_wait = 0.
  - io_download low -> IDLE.
- PAUSE:
  - cpu_pause_req = 1; 10-bit counter runs.
  - cpu_paused = 1 -> HS.
  - Counter reaches PAUSE_TO -> set err_timeout and go to HS anyway.
  - io_download rising here -> drop cpu_pause_req, go to IO (the session has not started).
- HS:
  - hs_gnt = 1; cpu_pause_req = 1; dn_nvram = 1; dn_addr = zero-extended hs_addr.
  - hs_wr -> dn_wr = 1 with dn_data = hs_wdata.
  - hs_rd -> read enters an RD_LAT+1 stage shift pipe. hs_rvalid pulses RD_LAT+1 cycles after hs_rd, with hs_rdata = dn_din sampled that cycle.
  - Back-to-back reads, one per cycle, are supported.
  - hs_rd and hs_wr in the same cycle: the write executes and the read is dropped (no rvalid).
  - hs_done or hs_req low -> RELEASE.
  - io_download asserted during HS: io_wait = 1; the session is not preempted.
- RELEASE:
  - hs_gnt = 0; cpu_pause_req stays 1; the read pipe drains and outstanding rvalids are still delivered.
  - Exit to IDLE when the pipe is empty AND hs_req = 0. cpu_pause_req drops on that exit.
  - io_wait remains 1 while io_download is asserted. IDLE then enters IO next cycle and io_wait drops.
- io_wait = io_download & (state in PAUSE-after-grant-pending? no): io_wait = io_download & state in {HS, RELEASE}.
- err_timeout is cleared only by reset.
- busy = (state != IDLE).

Test Plan:
- ROM load: io_download=1, io_index=0, io_wr at addr 0x0123 with data 0xA5 -> next cycle dn_addr=0x0123, dn_data=0xA5, dn_wr=1, dn_nvram=0. A write with io_index=3 gives dn_wr=0.
- Session: hs_req=1; cpu_paused rises 5 cycles later -> hs_gnt=1 the following cycle. hs_rd at addr 0x3FF with dn_din=0x5C -> dn_addr=0x03FF, hs_rvalid=1 with hs_rdata=0x5C exactly 3 cycles after hs_rd (RD_LAT=2).
- Burst plus release: 4 consecutive hs_rd, then hs_done on the cycle after the last read -> 4 rvalids delivered in order. cpu_pause_req drops only after the last rvalid and after hs_req=0.
- Contention: io_download asserted mid-HS -> io_wait=1 until the session ends. After RELEASE exits, io_wait=0 and the first io_wr appears on dn_*.
- Timeout: hs_req=1 with cpu_paused held 0 -> after 1023 cycles err_timeout=1 and hs_gnt=1. err_timeout stays 1 until reset.
- Reset mid-HS with 2 reads in flight -> hs_gnt, cpu_pause_req and hs_rvalid are 0 immediately. No rvalid is emitted after reset release.
